// File: rtl/gamepad_pmod_driver.sv
// Transmit-side Gamepad Pmod model: periodically latches two pad states and
// shifts 24 bits (controller 2 first) out on the latch/clk/data wires.
module gamepad_pmod_driver #(
  parameter int HALF_BIT     = 4,
  parameter int LATCH_CYCLES = 4,
  parameter int FRAME_PERIOD = 416666
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] buttons_1,
  input  logic        present_1,
  input  logic [11:0] buttons_2,
  input  logic        present_2,
  output logic        pmod_latch,
  output logic        pmod_clk,
  output logic        pmod_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int PCW   = $clog2(FRAME_PERIOD);
  localparam int MAXPH = (HALF_BIT > LATCH_CYCLES) ? HALF_BIT : LATCH_CYCLES;
  localparam int PHW   = $clog2(MAXPH + 1);

  localparam logic [PCW-1:0] PERIOD_LAST = PCW'(FRAME_PERIOD - 1);
  localparam logic [PHW-1:0] LATCH_LAST  = PHW'(LATCH_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_LAST   = PHW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t          state, state_n;
  logic [PCW-1:0]  period_cnt;
  logic [PHW-1:0]  phase, phase_n;
  logic [4:0]      bit_idx, bit_idx_n;
  logic [23:0]     sreg, sreg_n;
  logic [11:0]     pad_1, pad_2;
  logic            latch_n, clk_n, data_n, done_n, busy_n;

  // Absent pads read as all ones through the receiver's pull-ups.
  assign pad_1 = present_1 ? buttons_1 : 12'hFFF;
  assign pad_2 = present_2 ? buttons_2 : 12'hFFF;

  always_comb begin
    state_n   = state;
    phase_n   = phase + 1'b1;
    bit_idx_n = bit_idx;
    sreg_n    = sreg;
    case (state)
      IDLE: begin
        phase_n = '0;
        if (enable && period_cnt == '0) begin
          state_n   = LATCH;
          sreg_n    = {pad_2, pad_1};
          bit_idx_n = '0;
        end
      end
      LATCH: if (phase == LATCH_LAST) begin
        state_n = LOW;
        phase_n = '0;
      end
      LOW: if (phase == HALF_LAST) begin
        state_n = HIGH;
        phase_n = '0;
      end
      HIGH: if (phase == HALF_LAST) begin
        phase_n = '0;
        if (bit_idx == 5'd23) begin
          state_n = DONE;
        end else begin
          state_n   = LOW;
          bit_idx_n = bit_idx + 1'b1;
          sreg_n    = {sreg[22:0], 1'b0};
        end
      end
      DONE: begin
        state_n = IDLE;
        phase_n = '0;
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register with it.
    latch_n = (state_n == LATCH);
    clk_n   = (state_n == HIGH);
    data_n  = ((state_n == LOW) || (state_n == HIGH)) && sreg_n[23];
    done_n  = (state_n == DONE);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      phase      <= '0;
      bit_idx    <= '0;
      sreg       <= '0;
      pmod_latch <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_data  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      bit_idx    <= bit_idx_n;
      sreg       <= sreg_n;
      pmod_latch <= latch_n;
      pmod_clk   <= clk_n;
      pmod_data  <= data_n;
      frame_done <= done_n;
      busy       <= busy_n;
      if (!enable || period_cnt == PERIOD_LAST) period_cnt <= '0;
      else                                     period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule
